// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes produced by the ALU control
// decoder and the multi-cycle ALU sequencer state encoding.
package alu_pkg;

    // 3-bit ALU control codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_DIV  = 3'b110;
    localparam logic [2:0] ALU_RSVD = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiplier and unsigned restoring divider.
// 'load' captures the operands; each 'step' performs one iteration.
// 'res' presents the value the selected result will hold once the step
// taking place at the coming edge has been applied, so the sequencer can
// register the final answer on the same edge as the last iteration.
module alu_iter_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] res
);

    logic             r_is_div;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;

    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // Next-iteration values for both the multiplier and the divider
    always_comb begin
        w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_dvsr};
        // Negative trial difference means restore the shifted remainder
        w_rem_nxt = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
        res       = r_is_div ? w_quo_nxt : w_acc_nxt;
    end

    // Operand capture on load, one multiply/divide iteration per step
    always_ff @(posedge clk) begin
        if (load) begin
            r_is_div <= op_is_div;
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_rem    <= '0;
            r_quo    <= a;
            r_dvsr   <= b;
        end else if (step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle execution ALU: single-cycle add/sub/and/or/slt, iterative
// mul/div under a start/busy/done handshake with registered outputs.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    alu_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_iter_res;
    logic             w_is_div;
    logic             w_go_iter;
    logic             w_accept;

    // Single-cycle operation results and request classification
    always_comb begin
        w_single = '0;
        unique case (alu_ctrl)
            ALU_ADD: w_single = a + b;
            ALU_SUB: w_single = a - b;
            ALU_AND: w_single = a & b;
            ALU_OR:  w_single = a | b;
            ALU_SLT: w_single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_single = '0;
        endcase
        w_is_div  = (alu_ctrl == ALU_DIV);
        w_go_iter = (alu_ctrl == ALU_MUL) || (w_is_div && (b != '0));
        w_accept  = start && (r_state != ST_ITER);
    end

    alu_iter_unit #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .load     (w_accept && w_go_iter),
        .op_is_div(w_is_div),
        .a        (a),
        .b        (b),
        .step     (r_state == ST_ITER),
        .res      (w_iter_res)
    );

    // Sequencer: accept requests, count iterations, register results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_ITER: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_result <= w_iter_res;
                        r_zero   <= (w_iter_res == '0);
                        r_dbz    <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        if (w_go_iter) begin
                            r_cnt   <= CW'(WIDTH);
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_state <= ST_ITER;
                        end else if (w_is_div) begin
                            r_result <= '1;
                            r_zero   <= 1'b0;
                            r_dbz    <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_result <= w_single;
                            r_zero   <= (w_single == '0);
                            r_dbz    <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign result      = r_result;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: cycle-level behavioural model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_alu_multicycle;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    alu_ctrl;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  result;
    logic          zero;
    logic          div_by_zero;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    alu_multicycle #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .alu_ctrl   (alu_ctrl),
        .a          (a),
        .b          (b),
        .result     (result),
        .zero       (zero),
        .div_by_zero(div_by_zero),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: outputs after each edge, from arithmetic and a
    // remaining-latency count
    logic [W-1:0] m_result, m_pend;
    logic         m_zero, m_dbz, m_busy, m_done;
    int           m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_result = '0; m_zero = 1'b1; m_dbz = 1'b0;
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                m_result = m_pend; m_zero = (m_pend == 0); m_dbz = 1'b0;
                m_busy = 1'b0; m_done = 1'b1;
            end
        end else if (start) begin
            m_done = 1'b1;
            m_dbz  = 1'b0;
            case (alu_ctrl)
                3'd0: m_result = a + b;
                3'd1: m_result = a - b;
                3'd2: m_result = a & b;
                3'd3: m_result = a | b;
                3'd4: m_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd5: begin m_pend = a * b; m_left = W; end
                3'd6: begin
                    if (b == 0) begin m_result = '1; m_dbz = 1'b1; end
                    else begin m_pend = a / b; m_left = W; end
                end
                default: m_result = '0;
            endcase
            if (m_left > 0) begin
                m_done = 1'b0; m_busy = 1'b1;
            end else begin
                m_zero = (m_result == 0);
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_result", result, m_result);
            chk("cyc_zero", W'(zero), W'(m_zero));
            chk("cyc_dbz", W'(div_by_zero), W'(m_dbz));
            chk("cyc_busy", W'(busy), W'(m_busy));
            chk("cyc_done", W'(done), W'(m_done));
        end
    end

    // Drive a request at the current falling edge; returns one cycle later
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; alu_ctrl = op; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; alu_ctrl = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int  n;
    logic saw_done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; alu_ctrl = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", W'(zero), 32'd1);
        chk("rst_busy", W'(busy), 32'd0);
        chk("rst_done", W'(done), 32'd0);
        chk("rst_dbz", W'(div_by_zero), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'hFFFF_FFFF, 32'h1);
        chk("add_res", result, 32'h0);
        chk("add_zero", W'(zero), 32'd1);
        chk("add_done", W'(done), 32'd1);
        @(negedge clk);

        issue(3'd1, 32'd5, 32'd7);
        chk("sub_res", result, 32'hFFFF_FFFE);
        chk("sub_zero", W'(zero), 32'd0);
        @(negedge clk);

        issue(3'd4, 32'hFFFF_FFFF, 32'h1);
        chk("slt_neg", result, 32'd1);
        @(negedge clk);
        issue(3'd4, 32'h1, 32'hFFFF_FFFF);
        chk("slt_pos", result, 32'd0);
        @(negedge clk);
        issue(3'd7, 32'h1234, 32'h5678);
        chk("rsvd_res", result, 32'd0);
        @(negedge clk);

        issue(3'd5, 32'h0001_0003, 32'h0002_0005);
        wait_busy(n);
        chk("mul_busy_cycles", W'(n), 32'd32);
        chk("mul_done", W'(done), 32'd1);
        chk("mul_res", result, 32'h000B_000F);
        @(negedge clk);

        issue(3'd6, 32'd100, 32'd7);
        wait_busy(n);
        chk("div_busy_cycles", W'(n), 32'd32);
        chk("div_res", result, 32'd14);
        @(negedge clk);

        issue(3'd6, 32'd5, 32'd0);
        chk("div0_res", result, 32'hFFFF_FFFF);
        chk("div0_flag", W'(div_by_zero), 32'd1);
        chk("div0_done", W'(done), 32'd1);
        @(negedge clk);
        issue(3'd0, 32'd1, 32'd2);
        chk("add_after_div0", result, 32'd3);
        chk("dbz_cleared", W'(div_by_zero), 32'd0);
        @(negedge clk);

        // start held high with a different code during a multiply
        start = 1'b1; alu_ctrl = 3'd5; a = 32'h0001_0003; b = 32'h0002_0005;
        @(negedge clk);
        alu_ctrl = 3'd0; a = 32'd1; b = 32'd1;
        wait_busy(n);
        start = 1'b0;
        chk("mul_hold_cycles", W'(n), 32'd32);
        chk("mul_hold_res", result, 32'h000B_000F);
        @(negedge clk);

        // reset during busy cycle 10, with a start in the same cycle
        issue(3'd5, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", W'(busy), 32'd1);
        rst = 1'b1; start = 1'b1; alu_ctrl = 3'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("abort_result", result, 32'h0);
        chk("abort_zero", W'(zero), 32'd1);
        chk("abort_busy", W'(busy), 32'd0);
        chk("abort_done", W'(done), 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", W'(saw_done), 32'd0);

        // back-to-back single-cycle ops issued in DONE cycles
        issue(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("b2b_and", result, 32'h00F0_1200);
        chk("b2b_and_done", W'(done), 32'd1);
        issue(3'd3, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("b2b_or", result, 32'hFFF0_FF34);
        chk("b2b_or_done", W'(done), 32'd1);
        issue(3'd1, 32'd42, 32'd42);
        chk("b2b_beq_zero", W'(zero), 32'd1);
        @(negedge clk);
        chk("b2b_idle_done", W'(done), 32'd0);
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
